// File: rtl/noc_pkg.sv
// Shared router-wide sizing constants and types for the NoC output channel.
package noc_pkg;

  localparam int FLIT_W = 64;
  localparam int NUM_IN = 4;
  localparam int PTR_W  = $clog2(NUM_IN);

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [PTR_W-1:0]  port_idx_t;

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// Round-robin picker: rotate requests so ptr sits at position 0, take the lowest
// set bit, then rotate the result back to an absolute buffer index.
module rr_pick
  import noc_pkg::*;
#(
  parameter int N  = NUM_IN,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // One extra bit so ptr + offset never overflows before the modulo-N fold.
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [PW:0]   raw;
      logic [PW-1:0] src;
      assign raw     = {1'b0, ptr} + (PW+1)'(gi);
      assign src     = (raw >= N_W) ? PW'(raw - N_W) : raw[PW-1:0];
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= N_W) ? PW'(sum - N_W) : sum[PW-1:0];
    any = |req;
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Shares one router output channel among N full input buffers: round-robin grant,
// Mealy RE pulse to the winner, registered flit + WE pulse to the downstream buffer.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int N  = NUM_IN,
  parameter int DW = FLIT_W,
  parameter int PW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] din,
  input  logic            out_ready,
  output logic [N-1:0]    re,
  output logic [DW-1:0]   dout,
  output logic            out_valid,
  output logic [PW-1:0]   ptr
);

  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] win_idx;
  logic          pick_any;
  logic          can_grant;
  logic [PW-1:0] ptr_next;
  logic [DW-1:0] win_flit;
  logic [DW-1:0] din_arr [N];

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (win_idx),
    .any (pick_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_din
      assign din_arr[gi] = din[gi*DW +: DW];
    end
  endgenerate

  // ~out_valid forces a dead cycle: downstream full only rises one edge after WE.
  assign can_grant = out_ready & ~out_valid & pick_any & ~reset;
  assign re        = can_grant ? pick_gnt : '0;
  assign win_flit  = din_arr[win_idx];
  assign ptr_next  = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ptr       <= '0;
    end else if (can_grant) begin
      out_valid <= 1'b1;
      dout      <= win_flit;
      ptr       <= ptr_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench: a buffer/arbiter reference model queues expected flits; a monitor
// pops and compares whenever the cycle of an expected downstream write comes round.
module tb_output_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] din = '0;
  logic            out_ready = 1'b1;
  logic [N-1:0]    re;
  logic [DW-1:0]   dout;
  logic            out_valid;
  logic [PW-1:0]   ptr;

  output_port_arbiter #(.N(N), .DW(DW), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .re        (re),
    .dout      (dout),
    .out_valid (out_valid),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] flit;
    int          w;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // Stimulus state: what each input buffer holds, plus the model of the arbiter.
  bit          full [N];
  logic [63:0] flit [N];
  bit          rdy;
  bit          rst;
  int          mptr;
  bit          mvalid;
  logic [63:0] mdout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit          can;
    bit          anyf;
    int          w;
    logic [N-1:0] exp_re;
    @(posedge clk);
    #1;
    reset     = rst;
    out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req[i]            = full[i];
      din[i*DW +: DW]   = flit[i];
    end
    @(negedge clk);
    check("ptr", 64'(ptr), 64'(mptr));
    check("dout_hold", dout, mdout);
    anyf = 1'b0;
    for (int i = 0; i < N; i++) anyf |= full[i];
    can = !rst && rdy && !mvalid && anyf;
    w = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && full[(mptr + k) % N]) w = (mptr + k) % N;
      end
    end
    exp_re = can ? N'(1 << w) : '0;
    check("re", 64'(re), 64'(exp_re));
    if (rst) begin
      mptr   = 0;
      mvalid = 1'b0;
      mdout  = '0;
    end else if (can) begin
      sbq.push_back('{cyc + 1, flit[w], w});
      mdout   = flit[w];
      mptr    = (w + 1) % N;
      mvalid  = 1'b1;
      full[w] = 1'b0;
      $display("grant cyc=%0d w=%0d flit=%h ptr_next=%0d", cyc, w, flit[w], mptr);
    end else begin
      mvalid = 1'b0;
    end
  endtask

  task automatic set_full(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) full[i] = m[i];
  endtask

  task automatic refill_all();
    for (int i = 0; i < N; i++) begin
      if (!full[i]) begin
        full[i] = 1'b1;
        flit[i] = {$urandom, $urandom};
      end
    end
  endtask

  // Monitor: the downstream write pulse must occur exactly on the expected cycles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        check("out_valid", 64'(out_valid), 64'd1);
        check("dout", dout, e.flit);
      end else begin
        check("out_valid_idle", 64'(out_valid), 64'd0);
      end
    end
  end

  initial begin
    mptr   = 0;
    mvalid = 1'b0;
    mdout  = '0;
    for (int i = 0; i < N; i++) flit[i] = {$urandom, $urandom};

    // Reset held with every buffer requesting.
    rst = 1'b1;
    rdy = 1'b1;
    set_full(4'hF);
    repeat (2) step();

    // Single request from buffer 2.
    rst = 1'b0;
    set_full(4'b0100);
    flit[2] = 64'hA5A5;
    repeat (2) step();

    // All buffers kept full; refilled after each grant.
    for (int c = 0; c < 10; c++) begin
      refill_all();
      step();
    end

    // Downstream stalled, then released.
    set_full(4'b1001);
    rdy = 1'b0;
    repeat (5) step();
    rdy = 1'b1;
    repeat (2) step();

    // Pointer wrap from 3 back to 0.
    set_full(4'b0100);
    repeat (2) step();
    set_full(4'b1000);
    flit[3] = {$urandom, $urandom};
    repeat (2) step();
    set_full(4'b1001);
    repeat (2) step();

    // Reset arriving while out_valid is high.
    set_full(4'b0010);
    flit[1] = {$urandom, $urandom};
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Randomized traffic with stalls and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!full[i] && $urandom_range(0, 2) == 0) begin
          full[i] = 1'b1;
          flit[i] = {$urandom, $urandom};
        end
      end
      step();
    end

    // Drain so the last expected write is observed.
    rst = 1'b0;
    rdy = 1'b1;
    set_full(4'b0000);
    repeat (3) step();
    done = 1'b1;
    @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
